data_out_block: RTL and testbench

- Write-path transmitter for the Xccela OPI controller; counterpart of the DQS-captured read path.
- Buffers 16-bit write words and byte masks from the AXI write-data side in a small synchronous FIFO.
- On command, runs a latency/preamble/data/postamble sequence and presents rise/fall byte pairs for DQ, DM and DQS to external DDR output cells, with output enables.
- Single clock domain (clk); the DDR primitives outside the block do the 2x serialisation.

---
 rtl/data_out_block.sv | 181 ++++++++++++++++++
 tb/tb_data_out_block.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_out_block.sv
// OPI write-path transmitter: buffers 16-bit words plus byte masks and plays them out as
// rise/fall byte pairs on DQ/DM/DQS through a latency/preamble/data/postamble sequence.
module data_out_block #(
   parameter int MEM_LEN = 9,
   parameter int FIFO_AW = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wdata_valid,
   input  logic [15:0]        wdata_in,
   input  logic [1:0]         wmask_in,
   output logic               wfifo_full,
   output logic [FIFO_AW:0]   wfifo_count,
   input  logic               write_start,
   input  logic [MEM_LEN:0]   data_len,
   input  logic [3:0]         wlat,
   output logic               write_busy,
   output logic [7:0]         dq_out_r,
   output logic [7:0]         dq_out_f,
   output logic               dm_r,
   output logic               dm_f,
   output logic               dqs_r,
   output logic               dqs_f,
   output logic               dq_oe,
   output logic               dqs_oe,
   output logic [MEM_LEN:0]   wdata_count,
   output logic               wfifo_finish,
   output logic               wfifo_underrun
);

   localparam int DEPTH = 2**FIFO_AW;

   typedef struct packed {
      logic [1:0]  mask;
      logic [15:0] data;
   } wentry_t;

   typedef enum logic [2:0] {IDLE, LAT, PRE, DATA, POST, DONE} state_t;

   wentry_t            mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   wentry_t            head;
   logic               empty, push, load, pop;

   state_t             state;
   logic [MEM_LEN:0]   len_q;
   logic [3:0]         lat_cnt;

   logic [7:0]         beat_r, beat_f;
   logic               beat_mr, beat_mf;

   assign empty       = (count == '0);
   assign wfifo_full  = (count == (FIFO_AW+1)'(DEPTH));
   assign wfifo_count = count;
   assign push        = wdata_valid && !wfifo_full;
   assign head        = mem[rd_ptr];
   assign write_busy  = (state != IDLE);

   // Output registers load on the edge into DATA and on every DATA edge except the last,
   // so the head is consumed on those same edges.
   assign load = (state == PRE) || ((state == DATA) && (wdata_count != len_q));
   assign pop  = load && !empty;

   always_comb begin
      beat_r  = head.data[15:8];
      beat_f  = head.data[7:0];
      beat_mr = head.mask[1];
      beat_mf = head.mask[0];
      if (empty) begin
         beat_r  = 8'h00;
         beat_f  = 8'h00;
         beat_mr = 1'b1;
         beat_mf = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{mask: wmask_in, data: wdata_in};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         len_q          <= '0;
         lat_cnt        <= '0;
         wdata_count    <= '0;
         wfifo_underrun <= 1'b0;
         wfifo_finish   <= 1'b0;
         dq_out_r       <= 8'h00;
         dq_out_f       <= 8'h00;
         dm_r           <= 1'b0;
         dm_f           <= 1'b0;
         dqs_r          <= 1'b0;
         dqs_f          <= 1'b0;
         dq_oe          <= 1'b0;
         dqs_oe         <= 1'b0;
      end else begin
         wfifo_finish <= 1'b0;
         case (state)
            IDLE: begin
               if (write_start) begin
                  len_q          <= data_len;
                  lat_cnt        <= wlat;
                  wdata_count    <= '0;
                  wfifo_underrun <= 1'b0;
                  if (wlat != 4'd0) begin
                     state <= LAT;
                  end else begin
                     state  <= PRE;
                     dq_oe  <= 1'b1;
                     dqs_oe <= 1'b1;
                  end
               end
            end
            LAT: begin
               if (lat_cnt == 4'd1) begin
                  state  <= PRE;
                  dq_oe  <= 1'b1;
                  dqs_oe <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            PRE: begin
               state          <= DATA;
               dqs_r          <= 1'b1;
               dq_out_r       <= beat_r;
               dq_out_f       <= beat_f;
               dm_r           <= beat_mr;
               dm_f           <= beat_mf;
               wfifo_underrun <= wfifo_underrun | empty;
            end
            DATA: begin
               wdata_count <= wdata_count + (MEM_LEN+1)'(1);
               if (wdata_count == len_q) begin
                  state    <= POST;
                  dq_oe    <= 1'b0;
                  dqs_r    <= 1'b0;
                  dq_out_r <= 8'h00;
                  dq_out_f <= 8'h00;
                  dm_r     <= 1'b0;
                  dm_f     <= 1'b0;
               end else begin
                  dq_out_r       <= beat_r;
                  dq_out_f       <= beat_f;
                  dm_r           <= beat_mr;
                  dm_f           <= beat_mf;
                  wfifo_underrun <= wfifo_underrun | empty;
               end
            end
            POST: begin
               state        <= DONE;
               dqs_oe       <= 1'b0;
               wfifo_finish <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_out_block.sv
// Directed bench for data_out_block: sequencing, data ordering, masks, full FIFO,
// underrun, mid-burst reset and ignored write_start pulses.
module tb_data_out_block;

   logic        clk;
   logic        reset_n;
   logic        wdata_valid;
   logic [15:0] wdata_in;
   logic [1:0]  wmask_in;
   logic        wfifo_full;
   logic [5:0]  wfifo_count;
   logic        write_start;
   logic [9:0]  data_len;
   logic [3:0]  wlat;
   logic        write_busy;
   logic [7:0]  dq_out_r, dq_out_f;
   logic        dm_r, dm_f, dqs_r, dqs_f, dq_oe, dqs_oe;
   logic [9:0]  wdata_count;
   logic        wfifo_finish, wfifo_underrun;

   int total = 0;
   int bad   = 0;

   data_out_block #(.MEM_LEN(9), .FIFO_AW(5)) dut (
      .clk(clk), .reset_n(reset_n), .wdata_valid(wdata_valid), .wdata_in(wdata_in),
      .wmask_in(wmask_in), .wfifo_full(wfifo_full), .wfifo_count(wfifo_count),
      .write_start(write_start), .data_len(data_len), .wlat(wlat), .write_busy(write_busy),
      .dq_out_r(dq_out_r), .dq_out_f(dq_out_f), .dm_r(dm_r), .dm_f(dm_f),
      .dqs_r(dqs_r), .dqs_f(dqs_f), .dq_oe(dq_oe), .dqs_oe(dqs_oe),
      .wdata_count(wdata_count), .wfifo_finish(wfifo_finish), .wfifo_underrun(wfifo_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w, input logic [1:0] m);
      wdata_valid = 1'b1;
      wdata_in    = w;
      wmask_in    = m;
      tick();
      wdata_valid = 1'b0;
   endtask

   task automatic start(input logic [9:0] len, input logic [3:0] l);
      data_len    = len;
      wlat        = l;
      write_start = 1'b1;
      tick();
      write_start = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      reset_n = 1'b0; wdata_valid = 1'b0; wdata_in = '0; wmask_in = '0;
      write_start = 1'b0; data_len = '0; wlat = '0;
      tick(); tick();
      check("rst_count", wfifo_count, 0);
      check("rst_dq", {dq_out_r, dq_out_f}, 0);
      check("rst_oe", {dq_oe, dqs_oe, dqs_r, dqs_f, dm_r, dm_f}, 0);
      check("rst_flags", {write_busy, wfifo_finish, wfifo_underrun, wfifo_full}, 0);
      check("rst_wcnt", wdata_count, 0);
      reset_n = 1'b1;
      tick();

      // basic 4-word burst, wlat=2, with ignored start pulses in LAT and DATA
      push(16'hA1B2, 2'b00); push(16'hC3D4, 2'b00); push(16'hE5F6, 2'b00); push(16'h0718, 2'b00);
      check("t1_count", wfifo_count, 4);
      start(10'd3, 4'd2);
      check("t1_lat1_busy", write_busy, 1);
      check("t1_lat1_oe", {dq_oe, dqs_oe}, 0);
      data_len = 10'd0; wlat = 4'd5; write_start = 1'b1;
      tick();
      write_start = 1'b0;
      check("t1_lat2_oe", {dq_oe, dqs_oe}, 0);
      tick();
      check("t1_pre_oe", {dq_oe, dqs_oe}, 2'b11);
      check("t1_pre_dqs", {dqs_r, dqs_f, dq_out_r, dm_r, dm_f}, 0);
      tick();
      check("t1_b1_dq", {dq_out_r, dq_out_f}, 16'hA1B2);
      check("t1_b1_dqs", {dqs_r, dqs_f, dm_r, dm_f}, 4'b1000);
      check("t1_b1_wcnt", wdata_count, 0);
      write_start = 1'b1;
      tick();
      write_start = 1'b0;
      check("t1_b2_dq", {dq_out_r, dq_out_f}, 16'hC3D4);
      check("t1_b2_wcnt", wdata_count, 1);
      tick();
      check("t1_b3_dq", {dq_out_r, dq_out_f}, 16'hE5F6);
      tick();
      check("t1_b4_dq", {dq_out_r, dq_out_f}, 16'h0718);
      check("t1_b4_wcnt", wdata_count, 3);
      tick();
      check("t1_post_oe", {dq_oe, dqs_oe, dqs_r, dqs_f}, 4'b0100);
      check("t1_post_fin", wfifo_finish, 0);
      tick();
      check("t1_done_fin", wfifo_finish, 1);
      check("t1_done_oe", {dq_oe, dqs_oe}, 0);
      check("t1_done_count", wfifo_count, 0);
      check("t1_done_unr", wfifo_underrun, 0);
      tick();
      check("t1_idle", {wfifo_finish, write_busy}, 0);
      check("t1_wcnt_end", wdata_count, 4);

      // single beat, wlat=0, high byte masked
      push(16'h55AA, 2'b10);
      start(10'd0, 4'd0);
      check("t2_pre_oe", {dq_oe, dqs_oe, dqs_r}, 3'b110);
      tick();
      check("t2_b1_dq", {dq_out_r, dq_out_f}, 16'h55AA);
      check("t2_b1_dm", {dm_r, dm_f, dqs_r}, 3'b101);
      tick();
      check("t2_post", {dq_oe, dqs_oe}, 2'b01);
      tick();
      check("t2_done_fin", wfifo_finish, 1);
      tick();

      // fill to full, drop the 33rd word, stream 32 words out
      for (int i = 1; i <= 32; i++) begin
         b = 8'(i);
         push({b, ~b}, 2'b00);
      end
      check("t3_full", wfifo_full, 1);
      check("t3_count32", wfifo_count, 32);
      push(16'hFFFF, 2'b11);
      check("t3_drop_count", wfifo_count, 32);
      start(10'd31, 4'd1);
      tick();
      check("t3_pre_oe", {dq_oe, dqs_oe}, 2'b11);
      for (int k = 1; k <= 32; k++) begin
         tick();
         b = 8'(k);
         check($sformatf("t3_beat%0d", k), {dq_out_r, dq_out_f, dm_r, dm_f}, {b, ~b, 2'b00});
      end
      tick();
      check("t3_post", {dq_oe, dqs_oe}, 2'b01);
      tick();
      check("t3_done_fin", wfifo_finish, 1);
      check("t3_done_count", wfifo_count, 0);
      check("t3_done_unr", wfifo_underrun, 0);
      tick();

      // underrun: 4 beats from 2 words
      push(16'h1234, 2'b00); push(16'h5678, 2'b01);
      start(10'd3, 4'd0);
      tick();
      check("t4_b1", {dq_out_r, dq_out_f, dm_r, dm_f}, {16'h1234, 2'b00});
      check("t4_b1_unr", wfifo_underrun, 0);
      tick();
      check("t4_b2", {dq_out_r, dq_out_f, dm_r, dm_f}, {16'h5678, 2'b01});
      tick();
      check("t4_b3", {dq_out_r, dq_out_f, dm_r, dm_f}, {16'h0000, 2'b11});
      check("t4_b3_unr", wfifo_underrun, 1);
      tick();
      check("t4_b4", {dq_out_r, dq_out_f, dm_r, dm_f}, {16'h0000, 2'b11});
      tick();
      tick();
      check("t4_done_fin", wfifo_finish, 1);
      check("t4_done_unr", wfifo_underrun, 1);
      check("t4_count", wfifo_count, 0);
      tick();

      // reset during beat 2
      push(16'h1111, 2'b00); push(16'h2222, 2'b00); push(16'h3333, 2'b00);
      start(10'd2, 4'd0);
      tick();
      tick();
      check("t5_b2", {dq_out_r, dq_out_f}, 16'h2222);
      reset_n = 1'b0;
      tick();
      check("t5_rst_oe", {dq_oe, dqs_oe, dqs_r}, 0);
      check("t5_rst_busy", write_busy, 0);
      check("t5_rst_count", wfifo_count, 0);
      check("t5_rst_dq", {dq_out_r, dq_out_f}, 0);
      reset_n = 1'b1;
      tick();
      check("t5_no_fin", {wfifo_finish, write_busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
